// File: rtl/cpu_pkg.sv
// Shared types and constants for the 10-bit CPU control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_NAND = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_HALT = 3'b110;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [2:0] CLS_RA  = 3'b000;
  localparam logic [2:0] CLS_RB  = 3'b001;
  localparam logic [2:0] CLS_BNE = 3'b010;
  localparam logic [2:0] CLS_CMP = 3'b011;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: {class, func} to ALU op and control flags.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [2:0] alu_ctrl,
  output logic       write_flag,
  output logic       branch_flag,
  output logic       halt_flag,
  output logic       illegal_flag
);

  // Map opcode to ALU op and instruction class flags
  always_comb begin
    alu_ctrl     = ALU_ADD;
    write_flag   = 1'b0;
    branch_flag  = 1'b0;
    halt_flag    = 1'b0;
    illegal_flag = 1'b0;
    case (opcode[4:2])
      CLS_RA: begin
        alu_ctrl   = {1'b0, opcode[1:0]};
        write_flag = 1'b1;
      end
      CLS_RB: begin
        case (opcode[1:0])
          2'b00: begin
            alu_ctrl   = ALU_SRL;
            write_flag = 1'b1;
          end
          2'b01: begin
            alu_ctrl   = ALU_SLL;
            write_flag = 1'b1;
          end
          2'b10: begin
            alu_ctrl  = ALU_HALT;
            halt_flag = 1'b1;
          end
          default: alu_ctrl = ALU_CMP;
        endcase
      end
      CLS_BNE: begin
        alu_ctrl    = ALU_CMP;
        branch_flag = 1'b1;
      end
      CLS_CMP: alu_ctrl = ALU_SUB;
      default: illegal_flag = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit owning the PC.
// Optional CPU_CTRL_PERF_EN adds saturating cycle/instruction counters.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int PC_W    = 10,
  parameter int RADDR_W = 3,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [DATA_W-1:0]  rom_data,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [PC_W-1:0]    pc,
  output logic [RADDR_W-1:0] raddr1,
  output logic [RADDR_W-1:0] raddr2,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               we,
  output logic [2:0]         alu_ctrl,
  output logic               halted,
`ifdef CPU_CTRL_PERF_EN
  output logic [15:0]        cycle_cnt,
  output logic [15:0]        instr_cnt,
`endif
  output logic               illegal
);

  state_t              state_r;
  logic [DATA_W-1:0]   ir_r;
  logic [PC_W-1:0]     pc_r;
  logic [RADDR_W-1:0]  raddr1_r, raddr2_r, waddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r, halted_r, illegal_r;
  logic [2:0]          alu_ctrl_r;

  logic [4:0]          dec_opcode_s;
  logic [2:0]          dec_alu_s;
  logic                dec_write_s, dec_branch_s, dec_halt_s, dec_illegal_s;
  logic [PC_W-1:0]     pc_inc_s, br_tgt_s;

  // In DECODE the decoder looks at the fresh ROM word so alu_ctrl is ready at EXEC
  assign dec_opcode_s = (state_r == DECODE) ? {rom_data[9:7], rom_data[1:0]}
                                            : {ir_r[9:7], ir_r[1:0]};
  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign br_tgt_s = pc_inc_s + {{(PC_W-3){ir_r[2]}}, ir_r[2:0]};

  cpu_decode u_decode (
    .opcode       (dec_opcode_s),
    .alu_ctrl     (dec_alu_s),
    .write_flag   (dec_write_s),
    .branch_flag  (dec_branch_s),
    .halt_flag    (dec_halt_s),
    .illegal_flag (dec_illegal_s)
  );

  // Main sequencer with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      ir_r       <= {DATA_W{1'b0}};
      raddr1_r   <= {RADDR_W{1'b0}};
      raddr2_r   <= {RADDR_W{1'b0}};
      waddr_r    <= {RADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      alu_ctrl_r <= 3'b000;
      we_r       <= 1'b0;
      halted_r   <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          we_r    <= 1'b0;
          state_r <= run ? DECODE : FETCH;
        end
        DECODE: begin
          ir_r       <= rom_data;
          raddr1_r   <= {{(RADDR_W-2){1'b0}}, rom_data[6:5]};
          raddr2_r   <= {{(RADDR_W-2){1'b0}}, rom_data[4:3]};
          alu_ctrl_r <= dec_alu_s;
          state_r    <= EXEC;
        end
        EXEC: begin
          wdata_r <= alu_result;
          if (dec_halt_s) begin
            halted_r <= 1'b1;
            state_r  <= HALTED;
          end else begin
            we_r    <= dec_write_s;
            waddr_r <= {{(RADDR_W-2){1'b0}}, ir_r[4:3]};
            state_r <= WB;
          end
        end
        WB: begin
          we_r <= 1'b0;
          if (dec_illegal_s) illegal_r <= 1'b1;
          pc_r    <= (dec_branch_s && (wdata_r != {DATA_W{1'b0}})) ? br_tgt_s : pc_inc_s;
          state_r <= FETCH;
        end
        HALTED: begin
          we_r     <= 1'b0;
          halted_r <= 1'b1;
          state_r  <= HALTED;
        end
        default: begin
          we_r    <= 1'b0;
          state_r <= FETCH;
        end
      endcase
    end
  end

  assign pc       = pc_r;
  assign raddr1   = raddr1_r;
  assign raddr2   = raddr2_r;
  assign waddr    = waddr_r;
  assign wdata    = wdata_r;
  assign we       = we_r;
  assign alu_ctrl = alu_ctrl_r;
  assign halted   = halted_r;
  assign illegal  = illegal_r;

`ifdef CPU_CTRL_PERF_EN
  logic [15:0] cycle_cnt_r, instr_cnt_r;

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= 16'h0000;
      instr_cnt_r <= 16'h0000;
    end else begin
      if (state_r != HALTED && cycle_cnt_r != 16'hFFFF) cycle_cnt_r <= cycle_cnt_r + 16'h0001;
      if (state_r == WB && instr_cnt_r != 16'hFFFF) instr_cnt_r <= instr_cnt_r + 16'h0001;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm with behavioural ROM, RF and ALU.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [9:0] rom_data, alu_result, pc, wdata;
  logic [2:0] raddr1, raddr2, waddr, alu_ctrl;
  logic       we, halted, illegal;
`ifdef CPU_CTRL_PERF_EN
  logic [15:0] cycle_cnt, instr_cnt;
`endif

  logic [9:0] rom [0:1023];
  logic [9:0] rf  [0:7];
  int checks = 0;
  int errors = 0;

  localparam logic [9:0] I_NOP  = 10'b011_00_00_000;
  localparam logic [9:0] I_ADD  = 10'b000_01_10_0_00;
  localparam logic [9:0] I_SUB  = 10'b000_10_01_0_01;
  localparam logic [9:0] I_HALT = 10'b001_00_00_0_10;
  localparam logic [9:0] I_BNE2 = 10'b010_01_10_010;
  localparam logic [9:0] I_BNEM = 10'b010_01_10_101;
  localparam logic [9:0] I_ILL  = 10'b101_11_11_000;

  cpu_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .rom_data   (rom_data),
    .alu_result (alu_result),
    .pc         (pc),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .waddr      (waddr),
    .wdata      (wdata),
    .we         (we),
    .alu_ctrl   (alu_ctrl),
    .halted     (halted),
`ifdef CPU_CTRL_PERF_EN
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
`endif
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous ROM and register-file write port
  always @(posedge clk) begin
    rom_data <= rom[pc];
    if (we) rf[waddr] <= wdata;
  end

  // Reference ALU; cmp yields zero exactly when operands are equal
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = rf[raddr1] + rf[raddr2];
      3'b001:  alu_result = rf[raddr1] - rf[raddr2];
      3'b010:  alu_result = ($signed(rf[raddr1]) < $signed(rf[raddr2])) ? 10'd1 : 10'd0;
      3'b011:  alu_result = ~(rf[raddr1] & rf[raddr2]);
      3'b100:  alu_result = rf[raddr1] >> rf[raddr2][3:0];
      3'b101:  alu_result = rf[raddr1] << rf[raddr2][3:0];
      3'b110:  alu_result = 10'd0;
      default: alu_result = rf[raddr1] ^ rf[raddr2];
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic run_v);
    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    for (int i = 0; i < 8; i++) rf[i] = 10'd0;
    reset = 1'b0;
    run   = run_v;
    tick();
    tick();
  endtask

  task automatic wait_pc(input logic [9:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pc == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    setup(1'b1);
    checks++;
    if ({pc, raddr1, raddr2, waddr, wdata, alu_ctrl, we, halted, illegal} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%0d we=%0b halted=%0b illegal=%0b wdata=%0d expected all zero",
               pc, we, halted, illegal, wdata);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 16'd0 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
    end
`endif
  endtask

  task automatic test_add_sub;
    setup(1'b1);
    rom[0] = I_ADD;
    rom[1] = I_SUB;
    rf[1] = 10'd3;
    rf[2] = 10'd4;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (raddr1 !== 3'd1 || raddr2 !== 3'd2 || alu_ctrl !== 3'b000 || we !== 1'b0) begin
      errors++;
      $display("FAIL add_exec: got r1=%0d r2=%0d op=%0d we=%0b expected 1 2 0 0", raddr1, raddr2, alu_ctrl, we);
    end
    tick();
    checks++;
    if (we !== 1'b1 || waddr !== 3'd2 || wdata !== 10'd7 || pc !== 10'd0) begin
      errors++;
      $display("FAIL add_wb: got we=%0b waddr=%0d wdata=%0d pc=%0d expected 1 2 7 0", we, waddr, wdata, pc);
    end
    tick();
    checks++;
    if (we !== 1'b0 || pc !== 10'd1 || rf[2] !== 10'd7) begin
      errors++;
      $display("FAIL add_done: got we=%0b pc=%0d r2=%0d expected 0 1 7", we, pc, rf[2]);
    end
    tick();
    tick();
    tick();
    checks++;
    if (we !== 1'b1 || waddr !== 3'd1 || wdata !== 10'd4 || alu_ctrl !== 3'b001) begin
      errors++;
      $display("FAIL sub_wb: got we=%0b waddr=%0d wdata=%0d op=%0d expected 1 1 4 1", we, waddr, wdata, alu_ctrl);
    end
    tick();
    checks++;
    if (pc !== 10'd2 || rf[1] !== 10'd4) begin
      errors++;
      $display("FAIL sub_done: got pc=%0d r1=%0d expected 2 4", pc, rf[1]);
    end
`ifdef CPU_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 16'd8 || instr_cnt !== 16'd2) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d expected 8/2", cycle_cnt, instr_cnt);
    end
`endif
  endtask

  task automatic test_halt;
    bit ok;
    setup(1'b1);
    rom[5] = I_HALT;
    reset = 1'b1;
    wait_pc(10'd5, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL halt_reach: got pc=%0d expected 5 within budget", pc);
    end
    tick();
    tick();
    checks++;
    if (halted !== 1'b0 || alu_ctrl !== 3'b110) begin
      errors++;
      $display("FAIL halt_exec: got halted=%0b op=%0d expected 0 6", halted, alu_ctrl);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 10'd5) begin
      errors++;
      $display("FAIL halt_enter: got halted=%0b pc=%0d expected 1 5", halted, pc);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (we !== 1'b0 || pc !== 10'd5 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold: cycle %0d got we=%0b pc=%0d halted=%0b expected 0 5 1", i, we, pc, halted);
      end
    end
  endtask

  task automatic test_bne;
    logic [9:0] instr_v [3];
    logic [9:0] r2_v    [3];
    logic [9:0] exp_v   [3];
    bit ok;
    instr_v = '{I_BNE2, I_BNE2, I_BNEM};
    r2_v    = '{10'd2, 10'd1, 10'd2};
    exp_v   = '{10'd13, 10'd11, 10'd8};
    for (int k = 0; k < 3; k++) begin
      setup(1'b1);
      rom[10] = instr_v[k];
      rf[1] = 10'd1;
      rf[2] = r2_v[k];
      reset = 1'b1;
      wait_pc(10'd10, 60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bne_reach: case %0d got pc=%0d expected 10 within budget", k, pc);
      end
      tick();
      tick();
      tick();
      checks++;
      if (we !== 1'b0 || alu_ctrl !== 3'b111) begin
        errors++;
        $display("FAIL bne_wb: case %0d got we=%0b op=%0d expected 0 7", k, we, alu_ctrl);
      end
      tick();
      checks++;
      if (pc !== exp_v[k] || rf[2] !== r2_v[k]) begin
        errors++;
        $display("FAIL bne_target: case %0d got pc=%0d r2=%0d expected %0d %0d", k, pc, rf[2], exp_v[k], r2_v[k]);
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    setup(1'b1);
    reset = 1'b1;
    wait_pc(10'd1023, 4200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_reach: got pc=%0d expected 1023 within budget", pc);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc !== 10'd0) begin
      errors++;
      $display("FAIL wrap_pc: got %0d expected 0", pc);
    end
  endtask

  task automatic test_reset_mid;
    setup(1'b1);
    rom[0] = I_ADD;
    rf[1] = 10'd3;
    rf[2] = 10'd4;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (raddr1 !== 3'd1) begin
      errors++;
      $display("FAIL mid_exec: got raddr1=%0d expected 1", raddr1);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({pc, raddr1, raddr2, waddr, wdata, alu_ctrl, we, halted, illegal} !== 40'd0) begin
      errors++;
      $display("FAIL mid_async: got pc=%0d raddr1=%0d we=%0b wdata=%0d expected all zero", pc, raddr1, we, wdata);
    end
    tick();
    tick();
    checks++;
    if (we !== 1'b0 || rf[2] !== 10'd4) begin
      errors++;
      $display("FAIL mid_nowrite: got we=%0b r2=%0d expected 0 4", we, rf[2]);
    end
    reset = 1'b1;
  endtask

  task automatic test_run_illegal;
    setup(1'b0);
    rom[0] = I_ILL;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pc !== 10'd0 || raddr1 !== 3'd0 || we !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL run_low: got pc=%0d raddr1=%0d we=%0b illegal=%0b expected 0 0 0 0", pc, raddr1, we, illegal);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (raddr1 !== 3'd3 || raddr2 !== 3'd3) begin
      errors++;
      $display("FAIL run_drop: got raddr1=%0d raddr2=%0d expected 3 3", raddr1, raddr2);
    end
    tick();
    tick();
    checks++;
    if (pc !== 10'd1 || illegal !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_set: got pc=%0d illegal=%0b we=%0b expected 1 1 0", pc, illegal, we);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pc !== 10'd1) begin
      errors++;
      $display("FAIL run_low_hold: got pc=%0d expected 1", pc);
    end
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc !== 10'd2 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got pc=%0d illegal=%0b expected 2 1", pc, illegal);
    end
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    test_reset();
    test_add_sub();
    test_halt();
    test_bne();
    test_wrap();
    test_reset_mid();
    test_run_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
